// File: rtl/cpu_fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: redirect kinds,
// fetch state encoding and the halt opcode.
package cpu_fetch_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_JR     = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    HALTED = 2'b01,
    FAULT  = 2'b10
  } fetch_state_e;

  localparam logic [5:0] HALT_OPCODE = 6'b111111;

endpackage

// File: rtl/pc_next_calc.sv
// Redirect target computation; every target is taken relative to the PC of
// the last instruction handed to decode.
module pc_next_calc
  import cpu_fetch_pkg::*;
(
  input  logic [31:0] LastPC,
  input  logic [1:0]  PCSrc,
  input  logic [15:0] Imm16,
  input  logic [25:0] Target26,
  input  logic [31:0] RegTarget,
  output logic [31:0] Target
);

  logic [31:0] seq_pc;
  logic [31:0] br_offset;

  assign seq_pc    = LastPC + 32'd4;
  assign br_offset = {{14{Imm16[15]}}, Imm16, 2'b00};

  always_comb begin
    Target = seq_pc;
    case (pc_src_e'(PCSrc))
      PC_BRANCH: Target = seq_pc + br_offset;
      PC_JUMP:   Target = {seq_pc[31:28], Target26, 2'b00};
      PC_JR:     Target = RegTarget;
      default:   Target = seq_pc;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch front end: PC, combinational instruction-memory read, instruction
// register with valid/ready handshake to decode, redirect, halt and fault.
module pc_fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES  = 64,
  parameter logic [5:0]  HALT_OPCODE = cpu_fetch_pkg::HALT_OPCODE
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic [31:0] ImemAddr,
  output logic        ImemRW,
  input  logic [31:0] ImemData,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        RedirValid,
  input  logic [1:0]  PCSrc,
  input  logic [15:0] Imm16,
  input  logic [25:0] Target26,
  input  logic [31:0] RegTarget,
  output logic        Halted,
  output logic        Fault
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         valid_q, valid_d;
  logic [31:0]  last_pc_q, last_pc_d;

  logic [31:0]  redir_target;
  logic         handshake;
  logic         capture;
  logic         pc_legal;

  pc_next_calc u_next (
    .LastPC    (last_pc_q),
    .PCSrc     (PCSrc),
    .Imm16     (Imm16),
    .Target26  (Target26),
    .RegTarget (RegTarget),
    .Target    (redir_target)
  );

  assign handshake = valid_q && InstrReady;
  assign capture   = (state_q == RUN) && !RedirValid && (!valid_q || InstrReady);
  // Widened compare so a PC near 2^32 cannot wrap into the legal range.
  assign pc_legal  = (pc_q[1:0] == 2'b00) &&
                     (({1'b0, pc_q} + 33'd3) < 33'(IMEM_BYTES));

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    last_pc_d  = last_pc_q;

    if (handshake) last_pc_d = instr_pc_q;

    if (RedirValid) begin
      valid_d = 1'b0;
      pc_d    = redir_target;
      state_d = RUN;
    end else if (capture) begin
      if (pc_legal) begin
        instr_d    = ImemData;
        instr_pc_d = pc_q;
        valid_d    = 1'b1;
        if (ImemData[31:26] == HALT_OPCODE) state_d = HALTED;
        else                                pc_d    = pc_q + 32'd4;
      end else begin
        valid_d = 1'b0;
        state_d = FAULT;
      end
    end else if (handshake) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      last_pc_q  <= RESET_PC - 32'd4;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      last_pc_q  <= last_pc_d;
    end
  end

  assign ImemAddr   = pc_q;
  assign ImemRW     = 1'b1;
  assign Instr      = instr_q;
  assign InstrPC    = instr_pc_q;
  assign InstrValid = valid_q;
  assign Halted     = (state_q == HALTED);
  assign Fault      = (state_q == FAULT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: per-cycle vector table plus hand sequences for
// halt, fault and asynchronous reset; accepted instructions go via a scoreboard.
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] ImemAddr;
  logic        ImemRW;
  logic [31:0] ImemData;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic        InstrValid;
  logic        InstrReady;
  logic        RedirValid;
  logic [1:0]  PCSrc;
  logic [15:0] Imm16;
  logic [25:0] Target26;
  logic [31:0] RegTarget;
  logic        Halted;
  logic        Fault;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] mem [16];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [1:0]  src;
    logic [15:0] imm;
    logic [25:0] t26;
    logic [31:0] rt;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
  } vec_t;
  vec_t tbl[$];

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_BYTES(64)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .ImemAddr   (ImemAddr),
    .ImemRW     (ImemRW),
    .ImemData   (ImemData),
    .Instr      (Instr),
    .InstrPC    (InstrPC),
    .InstrValid (InstrValid),
    .InstrReady (InstrReady),
    .RedirValid (RedirValid),
    .PCSrc      (PCSrc),
    .Imm16      (Imm16),
    .Target26   (Target26),
    .RegTarget  (RegTarget),
    .Halted     (Halted),
    .Fault      (Fault)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    if (ImemAddr < 32'd64) ImemData = mem[ImemAddr[5:2]];
    else                   ImemData = 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Accepted instructions are compared against the scoreboard mid-cycle.
  always @(negedge CLK) begin
    if (!Reset && InstrValid && InstrReady) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_accept_pc", InstrPC, 32'hFFFF_FFFF);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        chk("sb_pc", InstrPC, e.pc);
        chk("sb_instr", Instr, e.word);
      end
    end
  end

  // Drive this cycle's inputs, check this cycle's outputs, then advance one edge.
  task automatic cyc(input string tag, input logic rdy, input logic redir,
                     input logic [1:0] src, input logic [15:0] imm,
                     input logic [25:0] t26, input logic [31:0] rt,
                     input logic ev, input logic [31:0] epc, input logic [31:0] eaddr,
                     input logic eh, input logic ef);
    InstrReady = rdy;
    RedirValid = redir;
    PCSrc      = src;
    Imm16      = imm;
    Target26   = t26;
    RegTarget  = rt;
    chk({tag, "_valid"},  {31'b0, InstrValid}, {31'b0, ev});
    chk({tag, "_addr"},   ImemAddr, eaddr);
    chk({tag, "_halted"}, {31'b0, Halted}, {31'b0, eh});
    chk({tag, "_fault"},  {31'b0, Fault},  {31'b0, ef});
    chk({tag, "_rw"},     {31'b0, ImemRW}, 32'd1);
    if (ev) chk({tag, "_ipc"}, InstrPC, epc);
    if (ev && rdy) sbq.push_back('{epc, mem[epc[5:2]]});
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"},   ImemAddr, 32'h0);
    chk({tag, "_instr"},  Instr, 32'h0);
    chk({tag, "_ipc"},    InstrPC, 32'h0);
    chk({tag, "_valid"},  {31'b0, InstrValid}, 32'd0);
    chk({tag, "_halted"}, {31'b0, Halted}, 32'd0);
    chk({tag, "_fault"},  {31'b0, Fault}, 32'd0);
  endtask

  initial begin
    Reset = 1'b1; InstrReady = 1'b1; RedirValid = 1'b0;
    PCSrc = 2'b00; Imm16 = '0; Target26 = '0; RegTarget = '0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h111;

    //          rdy   redir src    imm       t26     rt      ev    epc    eaddr
    tbl.push_back('{1'b1, 1'b0, 2'b00, 16'h0000, 26'h0, 32'h0,  1'b0, 32'd0,  32'd0});
    tbl.push_back('{1'b1, 1'b0, 2'b00, 16'h0000, 26'h0, 32'h0,  1'b1, 32'd0,  32'd4});
    tbl.push_back('{1'b0, 1'b0, 2'b00, 16'h0000, 26'h0, 32'h0,  1'b1, 32'd4,  32'd8});
    tbl.push_back('{1'b0, 1'b0, 2'b00, 16'h0000, 26'h0, 32'h0,  1'b1, 32'd4,  32'd8});
    tbl.push_back('{1'b0, 1'b0, 2'b00, 16'h0000, 26'h0, 32'h0,  1'b1, 32'd4,  32'd8});
    tbl.push_back('{1'b1, 1'b0, 2'b00, 16'h0000, 26'h0, 32'h0,  1'b1, 32'd4,  32'd8});
    tbl.push_back('{1'b1, 1'b0, 2'b00, 16'h0000, 26'h0, 32'h0,  1'b1, 32'd8,  32'd12});
    tbl.push_back('{1'b0, 1'b1, 2'b01, 16'hFFFE, 26'h0, 32'h0,  1'b1, 32'd12, 32'd16});
    tbl.push_back('{1'b1, 1'b0, 2'b00, 16'h0000, 26'h0, 32'h0,  1'b0, 32'd0,  32'd4});
    tbl.push_back('{1'b1, 1'b1, 2'b10, 16'h0000, 26'h5, 32'h0,  1'b1, 32'd4,  32'd8});
    tbl.push_back('{1'b1, 1'b0, 2'b00, 16'h0000, 26'h0, 32'h0,  1'b0, 32'd0,  32'd20});
    tbl.push_back('{1'b1, 1'b1, 2'b11, 16'h0000, 26'h0, 32'h10, 1'b1, 32'd20, 32'd24});
    tbl.push_back('{1'b1, 1'b0, 2'b00, 16'h0000, 26'h0, 32'h0,  1'b0, 32'd0,  32'd16});
    tbl.push_back('{1'b1, 1'b0, 2'b00, 16'h0000, 26'h0, 32'h0,  1'b1, 32'd16, 32'd20});
    tbl.push_back('{1'b1, 1'b0, 2'b00, 16'h0000, 26'h0, 32'h0,  1'b1, 32'd20, 32'd24});

    @(posedge CLK);
    #1;
    chk_reset("reset");
    chk("reset_rw", {31'b0, ImemRW}, 32'd1);
    Reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++)
      cyc($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].redir, tbl[i].src, tbl[i].imm,
          tbl[i].t26, tbl[i].rt, tbl[i].ev, tbl[i].epc, tbl[i].eaddr, 1'b0, 1'b0);

    // Halt: the halt word is presented, then fetch stays parked until a redirect.
    mem[3] = 32'hFC00_0000;
    cyc("h_jr8",  1'b1, 1'b1, 2'b11, 16'h0, 26'h0, 32'd8, 1'b1, 32'd24, 32'd28, 1'b0, 1'b0);
    cyc("h_cap8", 1'b1, 1'b0, 2'b00, 16'h0, 26'h0, 32'd0, 1'b0, 32'd0,  32'd8,  1'b0, 1'b0);
    cyc("h_v8",   1'b1, 1'b0, 2'b00, 16'h0, 26'h0, 32'd0, 1'b1, 32'd8,  32'd12, 1'b0, 1'b0);
    chk("h_word", Instr, 32'hFC00_0000);
    cyc("h_v12",  1'b1, 1'b0, 2'b00, 16'h0, 26'h0, 32'd0, 1'b1, 32'd12, 32'd12, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++)
      cyc($sformatf("h_idle%0d", i), 1'b1, 1'b0, 2'b00, 16'h0, 26'h0, 32'd0,
          1'b0, 32'd0, 32'd12, 1'b1, 1'b0);
    cyc("h_jr0",  1'b1, 1'b1, 2'b11, 16'h0, 26'h0, 32'd0, 1'b0, 32'd0,  32'd12, 1'b1, 1'b0);
    mem[3] = 32'h1000_0333;
    cyc("h_run",  1'b1, 1'b0, 2'b00, 16'h0, 26'h0, 32'd0, 1'b0, 32'd0,  32'd0,  1'b0, 1'b0);
    cyc("h_v0",   1'b1, 1'b0, 2'b00, 16'h0, 26'h0, 32'd0, 1'b1, 32'd0,  32'd4,  1'b0, 1'b0);

    // Misaligned redirect target faults on the following capture attempt.
    cyc("f_jr6",  1'b1, 1'b1, 2'b11, 16'h0, 26'h0, 32'd6, 1'b1, 32'd4,  32'd8,  1'b0, 1'b0);
    cyc("f_try6", 1'b1, 1'b0, 2'b00, 16'h0, 26'h0, 32'd0, 1'b0, 32'd0,  32'd6,  1'b0, 1'b0);
    cyc("f_flt6", 1'b1, 1'b0, 2'b00, 16'h0, 26'h0, 32'd0, 1'b0, 32'd0,  32'd6,  1'b0, 1'b1);
    cyc("f_hold", 1'b1, 1'b0, 2'b00, 16'h0, 26'h0, 32'd0, 1'b0, 32'd0,  32'd6,  1'b0, 1'b1);

    // Running off the end of instruction memory: 60 is the last legal word.
    cyc("e_jr56", 1'b1, 1'b1, 2'b11, 16'h0, 26'h0, 32'd56, 1'b0, 32'd0, 32'd6,  1'b0, 1'b1);
    cyc("e_c56",  1'b1, 1'b0, 2'b00, 16'h0, 26'h0, 32'd0, 1'b0, 32'd0,  32'd56, 1'b0, 1'b0);
    cyc("e_v56",  1'b1, 1'b0, 2'b00, 16'h0, 26'h0, 32'd0, 1'b1, 32'd56, 32'd60, 1'b0, 1'b0);
    cyc("e_v60",  1'b1, 1'b0, 2'b00, 16'h0, 26'h0, 32'd0, 1'b1, 32'd60, 32'd64, 1'b0, 1'b0);
    cyc("e_f64",  1'b1, 1'b0, 2'b00, 16'h0, 26'h0, 32'd0, 1'b0, 32'd0,  32'd64, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a cycle with a valid instruction held.
    cyc("r_jr0",  1'b1, 1'b1, 2'b11, 16'h0, 26'h0, 32'd0, 1'b0, 32'd0,  32'd64, 1'b0, 1'b1);
    cyc("r_cap",  1'b0, 1'b0, 2'b00, 16'h0, 26'h0, 32'd0, 1'b0, 32'd0,  32'd0,  1'b0, 1'b0);
    chk("r_pre_valid", {31'b0, InstrValid}, 32'd1);
    chk("r_pre_addr",  ImemAddr, 32'd4);
    #2;
    Reset = 1'b1;
    #1;
    chk_reset("r_async");
    @(posedge CLK);
    #1;
    Reset = 1'b0;

    // PC_SEQ redirect straight after reset lands on LastPC+4 = RESET_PC.
    cyc("s_idle", 1'b1, 1'b0, 2'b00, 16'h0, 26'h0, 32'd0, 1'b0, 32'd0,  32'd0,  1'b0, 1'b0);
    cyc("s_seq",  1'b1, 1'b1, 2'b00, 16'h0, 26'h0, 32'd0, 1'b1, 32'd0,  32'd4,  1'b0, 1'b0);
    cyc("s_cap",  1'b1, 1'b0, 2'b00, 16'h0, 26'h0, 32'd0, 1'b0, 32'd0,  32'd0,  1'b0, 1'b0);
    cyc("s_v0",   1'b1, 1'b0, 2'b00, 16'h0, 26'h0, 32'd0, 1'b1, 32'd0,  32'd4,  1'b0, 1'b0);

    chk("sb_leftover", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch front end of the CPU: owns the program counter, drives the instruction memory read port, and captures each returned big-endian 32-bit word into an instruction register. That register is presented to decode over a valid/ready handshake. It computes redirect targets (branch, jump, jump-register) from decode requests, and stops fetching on a halt opcode or an illegal fetch address.

## Interface
- RESET_PC, 32'h0000_0000: PC value after reset.
- IMEM_BYTES, 64: instruction memory size in bytes; a legal fetch needs PC+3 < IMEM_BYTES.
- HALT_OPCODE, 6'b111111: opcode field (bits 31:26) that halts fetch.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- ImemAddr  out  32  byte address to instruction memory; always equals PC.
- ImemRW  out  1  tied 1 (read); the fetch unit never writes instruction memory.
- ImemData  in  32  combinational read data for ImemAddr.
- Instr  out  32  instruction register.
- InstrPC  out  32  byte address of Instr.
- InstrValid  out  1  Instr/InstrPC hold an instruction for decode.
- InstrReady  in  1  decode accepts Instr this cycle.
- RedirValid  in  1  decode requests a PC redirect this cycle.
- PCSrc  in  2  redirect kind: 00 none/sequential, 01 branch, 10 jump, 11 jump-register.
- Imm16  in  16  branch offset in words, signed.
- Target26  in  26  jump target field.
- RegTarget  in  32  jump-register target.
- Halted  out  1  fetch stopped on HALT_OPCODE.
- Fault  out  1  fetch stopped on a misaligned or out-of-range PC.

## Operation
- States: RUN, HALTED, FAULT.
- Internal LastPC is loaded with InstrPC on every handshake (InstrValid && InstrReady). Redirects are relative to LastPC.
- Capture condition: state RUN, !RedirValid, and (!InstrValid || InstrReady).
- On capture with a legal PC:
  - Instr <= ImemData, InstrPC <= PC, InstrValid <= 1.
  - If ImemData[31:26] == HALT_OPCODE: PC unchanged, state -> HALTED. The halt word itself is still presented to decode.
  - Otherwise PC <= PC+4.
- Capture condition met but PC illegal (PC[1:0] != 0 or PC+3 >= IMEM_BYTES): no capture, state -> FAULT, PC unchanged.
- Handshake without capture: InstrValid <= 0.
- RedirValid (any state):
  - Flushes the IR: InstrValid <= 0. The word currently on ImemData is discarded.
  - Loads PC with the target; state -> RUN, which clears a speculative HALTED or FAULT.
  - Targets, all modulo 2^32:
    - branch: LastPC+4+(sign_extend(Imm16)<<2)
    - jump: {(LastPC+4)[31:28], Target26, 2'b00}
    - jump-register: RegTarget unmodified
    - PCSrc 00: LastPC+4.
  - LastPC still updates if a handshake occurs in the same cycle. The target uses the pre-edge LastPC.
- A misaligned redirect target is accepted into PC and faults on the next capture attempt.
- Halted = (state == HALTED); Fault = (state == FAULT).

## Timing
- Reset values: PC = RESET_PC, Instr = 0, InstrPC = 0, InstrValid = 0, LastPC = RESET_PC−4, state RUN, Halted = 0, Fault = 0. ImemAddr = RESET_PC combinationally.
- First edge after Reset deasserts captures the word at RESET_PC; InstrValid is 1 in the following cycle.
- Throughput: one instruction per cycle with InstrReady held high. Instruction-memory latency is zero; the read is combinational within the cycle.
- Backpressure: while InstrValid && !InstrReady, Instr, InstrPC and PC are held stable.
- Redirect-to-valid latency: 1 cycle. The redirect edge loads PC, the next edge captures the target word.
- Reset mid-operation immediately restores all reset values.

## Structure
- Shared package cpu_fetch_pkg:
  - PCSrc encodings (PC_SEQ, PC_BRANCH, PC_JUMP, PC_JR).
  - fetch state enum (RUN, HALTED, FAULT).
  - HALT_OPCODE constant.
- One combinational sub-module pc_next_calc: inputs LastPC, PCSrc, Imm16, Target26, RegTarget; output redirect target.
- State register, PC, IR and handshake logic stay in pc_fetch_unit.

## Test plan
- Straight-line run: reset, InstrReady=1, memory holds words W0..W3 at 0,4,8,12 -> InstrPC 0,4,8,12 on consecutive cycles with Instr = W0..W3, and ImemRW stays 1.
- Backpressure: InstrReady low for 3 cycles while InstrValid=1 at InstrPC=4 -> Instr, InstrPC and PC are unchanged. Raise InstrReady -> InstrPC=8 on the next cycle.
- Branch: accept instruction at 8, then RedirValid with PCSrc=01, Imm16=16'hFFFE -> the pending word at 12 is flushed (InstrValid=0 for 1 cycle), then InstrPC=4.
- Jump and jump-register:
  - PCSrc=10 with Target26=26'h5 -> next InstrPC=20.
  - PCSrc=11 with RegTarget=32'h10 -> next InstrPC=16.
- Halt: word 32'hFC00_0000 at 12 -> Instr presented with InstrPC=12, Halted=1, and no further captures for 10 cycles. A redirect to 0 then clears Halted and refetches from 0.
- Faults:
  - RegTarget=32'h6 -> Fault=1, InstrValid stays 0.
  - Sequential run to PC=64 with IMEM_BYTES=64 -> Fault=1.
  - Reset asserted mid-run -> all outputs return to reset values on assertion, without waiting for a clock edge.
